dm_arbiter: RTL and testbench

//  Two-requester arbiter and sequencer in front of the single-port data memory (dm).

---
 rtl/dm_arbiter_pkg.sv | 25 ++
 rtl/dm_arbiter_arb2_pick.sv | 52 +++++
 rtl/dm_arbiter.sv | 141 ++++++++++++++
 tb/tb_dm_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: dm op codes, sequencer states, sizing helper.
package dm_arbiter_pkg;

  localparam int unsigned DM_DW  = 32;
  localparam int unsigned DM_OPW = 3;

  localparam logic [DM_OPW-1:0] DM_OP_WD = 3'd0;
  localparam logic [DM_OPW-1:0] DM_OP_BS = 3'd1;
  localparam logic [DM_OPW-1:0] DM_OP_BZ = 3'd2;
  localparam logic [DM_OPW-1:0] DM_OP_HS = 3'd3;
  localparam logic [DM_OPW-1:0] DM_OP_HZ = 3'd4;
  localparam logic [DM_OPW-1:0] DM_OP_SB = 3'd5;
  localparam logic [DM_OPW-1:0] DM_OP_SH = 3'd6;

  typedef enum logic {
    DMA_S_IDLE  = 1'b0,
    DMA_S_ISSUE = 1'b1
  } dma_state_t;

  // Width of the m1 starvation counter; it only ever needs to reach smax-1.
  function automatic int unsigned starve_cw(input int unsigned smax);
    return (smax > 1) ? $clog2(smax) : 1;
  endfunction

endpackage

// File: rtl/dm_arbiter_arb2_pick.sv
// Two-way winner pick (0 cycles, combinational) with last-winner and m1 starvation state.
// Losers get no feedback other than a missing win; state moves only when advance is high.
module dm_arbiter_arb2_pick
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned RR_EN      = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_advance,
  output logic o_win0,
  output logic o_win1
);

  localparam int unsigned   CW      = starve_cw(STARVE_MAX);
  localparam logic [CW-1:0] CNT_LIM = CW'(STARVE_MAX - 1);

  logic          r_last1;
  logic [CW-1:0] r_starve;
  logic          w_tie_m1;

  // Tie-break: round-robin alternates, fixed priority only yields to m1 once it has starved.
  always_comb begin
    w_tie_m1 = 1'b0;
    if (RR_EN != 0) begin
      w_tie_m1 = ~r_last1;
    end else begin
      w_tie_m1 = (r_starve == CNT_LIM);
    end
  end

  assign o_win1 = i_req1 & (~i_req0 | w_tie_m1);
  assign o_win0 = i_req0 & ~o_win1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last1  <= 1'b1;
      r_starve <= '0;
    end else if (i_advance && (o_win0 || o_win1)) begin
      r_last1 <= o_win1;
      if (o_win1) begin
        r_starve <= '0;
      end else if (i_req1 && (r_starve != CNT_LIM)) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates LSU (m0) and debug master (m1) onto single-port dm: gnt same cycle, dm access +1, rvalid +2.
// No queueing: a losing requester simply keeps req high until its gnt pulse.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned RR_EN      = 1,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned AW         = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [AW-1:0]     i_m0_addr,
  input  logic [DM_DW-1:0]  i_m0_wdata,
  input  logic [DM_OPW-1:0] i_m0_op,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DM_DW-1:0]  o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [AW-1:0]     i_m1_addr,
  input  logic [DM_DW-1:0]  i_m1_wdata,
  input  logic [DM_OPW-1:0] i_m1_op,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DM_DW-1:0]  o_m1_rdata,
  output logic              o_dm_w,
  output logic              o_dm_r,
  output logic [AW-1:0]     o_dm_addr,
  output logic [DM_DW-1:0]  o_dm_wdata,
  output logic [DM_OPW-1:0] o_dm_op,
  input  logic [DM_DW-1:0]  i_dm_rdata
);

  typedef struct packed {
    logic              port;
    logic              we;
    logic [AW-1:0]     addr;
    logic [DM_DW-1:0]  wdata;
    logic [DM_OPW-1:0] op;
  } acc_t;

  dma_state_t       r_state;
  dma_state_t       w_state_nxt;
  acc_t             r_acc;
  acc_t             w_acc_sel;
  logic             w_pick0;
  logic             w_pick1;
  logic             w_win0;
  logic             w_win1;
  logic             w_any_gnt;
  logic             w_issue_rd;
  logic             r_m0_rvalid;
  logic             r_m1_rvalid;
  logic [DM_DW-1:0] r_m0_rdata;
  logic [DM_DW-1:0] r_m1_rdata;

  dm_arbiter_arb2_pick #(
    .RR_EN      (RR_EN),
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req0    (i_m0_req),
    .i_req1    (i_m1_req),
    .i_advance (i_rst_n),
    .o_win0    (w_pick0),
    .o_win1    (w_pick1)
  );

  // Grants are combinational from req, so mask them while reset is held.
  assign w_win0    = w_pick0 & i_rst_n;
  assign w_win1    = w_pick1 & i_rst_n;
  assign w_any_gnt = w_win0 | w_win1;

  assign w_acc_sel = w_win1 ? '{port: 1'b1, we: i_m1_we, addr: i_m1_addr, wdata: i_m1_wdata, op: i_m1_op}
                            : '{port: 1'b0, we: i_m0_we, addr: i_m0_addr, wdata: i_m0_wdata, op: i_m0_op};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= DMA_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_dm_w      = 1'b0;
    o_dm_r      = 1'b0;
    o_m0_gnt    = w_win0;
    o_m1_gnt    = w_win1;
    case (r_state)
      DMA_S_IDLE: begin
        if (w_any_gnt) w_state_nxt = DMA_S_ISSUE;
      end
      DMA_S_ISSUE: begin
        o_dm_w = r_acc.we;
        o_dm_r = ~r_acc.we;
        if (!w_any_gnt) w_state_nxt = DMA_S_IDLE;
      end
      default: w_state_nxt = DMA_S_IDLE;
    endcase
  end

  // The latch doubles as the dm bus driver, so the bus holds its last value between accesses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (w_any_gnt) begin
      r_acc <= w_acc_sel;
    end
  end

  assign o_dm_addr  = r_acc.addr;
  assign o_dm_wdata = r_acc.wdata;
  assign o_dm_op    = r_acc.op;

  assign w_issue_rd = o_dm_r;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_issue_rd & ~r_acc.port;
      r_m1_rvalid <= w_issue_rd & r_acc.port;
      if (w_issue_rd && !r_acc.port) r_m0_rdata <= i_dm_rdata;
      if (w_issue_rd && r_acc.port)  r_m1_rdata <= i_dm_rdata;
    end
  end

  assign o_m0_rvalid = r_m0_rvalid;
  assign o_m1_rvalid = r_m1_rvalid;
  assign o_m0_rdata  = r_m0_rdata;
  assign o_m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a round-robin instance and a fixed-priority (STARVE_MAX=3) instance side by side,
// each with its own dm memory, checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int NI = 2;
  localparam int MW = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clear;
  always #5 clk = ~clk;

  logic        req    [NI][2];
  logic        we     [NI][2];
  logic [31:0] addr   [NI][2];
  logic [31:0] wdata  [NI][2];
  logic [2:0]  op     [NI][2];
  logic        gnt    [NI][2];
  logic        rvalid [NI][2];
  logic [31:0] rdata  [NI][2];
  logic        dm_w     [NI];
  logic        dm_r     [NI];
  logic [31:0] dm_addr  [NI];
  logic [31:0] dm_wdata [NI];
  logic [2:0]  dm_op    [NI];
  logic [31:0] dm_rdata [NI];

  function automatic logic [31:0] mem_init(input int w);
    if (w == 4) return 32'hA1B2C3D4;
    return (32'(w) * 32'h01010101) ^ 32'h5A000000;
  endfunction

  function automatic logic [31:0] dm_rd(input logic [31:0] word, input logic [31:0] a, input logic [2:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a[1:0], 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (o)
      DM_OP_BS: return {{24{b[7]}}, b};
      DM_OP_BZ: return {24'h0, b};
      DM_OP_HS: return {{16{h[15]}}, h};
      DM_OP_HZ: return {16'h0, h};
      default:  return word;
    endcase
  endfunction

  function automatic logic [31:0] dm_wr(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic [2:0] o);
    logic [31:0] r;
    r = old;
    case (o)
      DM_OP_SB: r[{a[1:0], 3'b000} +: 8] = d[7:0];
      DM_OP_SH: r[{a[1], 4'b0000} +: 16] = d[15:0];
      default:  r = d;
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [31:0] mem [MW];

    dm_arbiter #(
      .RR_EN      ((g == 0) ? 1 : 0),
      .STARVE_MAX ((g == 0) ? 8 : 3),
      .AW         (32)
    ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_m0_req    (req[g][0]),
      .i_m0_we     (we[g][0]),
      .i_m0_addr   (addr[g][0]),
      .i_m0_wdata  (wdata[g][0]),
      .i_m0_op     (op[g][0]),
      .o_m0_gnt    (gnt[g][0]),
      .o_m0_rvalid (rvalid[g][0]),
      .o_m0_rdata  (rdata[g][0]),
      .i_m1_req    (req[g][1]),
      .i_m1_we     (we[g][1]),
      .i_m1_addr   (addr[g][1]),
      .i_m1_wdata  (wdata[g][1]),
      .i_m1_op     (op[g][1]),
      .o_m1_gnt    (gnt[g][1]),
      .o_m1_rvalid (rvalid[g][1]),
      .o_m1_rdata  (rdata[g][1]),
      .o_dm_w      (dm_w[g]),
      .o_dm_r      (dm_r[g]),
      .o_dm_addr   (dm_addr[g]),
      .o_dm_wdata  (dm_wdata[g]),
      .o_dm_op     (dm_op[g]),
      .i_dm_rdata  (dm_rdata[g])
    );

    always @(posedge clk) begin
      if (mem_clear) begin
        for (int i = 0; i < MW; i++) mem[i] <= mem_init(i);
      end else if (dm_w[g]) begin
        mem[dm_addr[g][7:2]] <= dm_wr(mem[dm_addr[g][7:2]], dm_addr[g], dm_wdata[g], dm_op[g]);
      end
    end

    assign dm_rdata[g] = dm_rd(mem[dm_addr[g][7:2]], dm_addr[g], dm_op[g]);
  end

  // Reference model: per-instance arbitration history plus a two-deep access pipeline.
  int          checks;
  int          failures;
  int          rr     [NI];
  int          smax   [NI];
  int          m_last [NI];
  int          m_starve [NI];
  bit          s1_vld [NI];
  bit          s1_port [NI];
  bit          s1_we  [NI];
  logic [31:0] s1_addr [NI];
  logic [31:0] s1_wdata [NI];
  logic [2:0]  s1_op  [NI];
  bit          s2_vld [NI];
  bit          s2_port [NI];
  logic [31:0] s2_data [NI];
  logic [31:0] m_rdata [NI][2];
  logic [31:0] ref_mem [NI][MW];
  bit          last_gnt [NI][2];

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", name, g, $time, act, exp);
    end
  endtask

  function automatic int pick(input int g, input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (rr[g] != 0) return (m_last[g] == 0) ? 1 : 0;
    return (m_starve[g] == smax[g] - 1) ? 1 : 0;
  endfunction

  task automatic model_step();
    int w;
    for (int g = 0; g < NI; g++) begin
      last_gnt[g][0] = gnt[g][0];
      last_gnt[g][1] = gnt[g][1];
      if (mem_clear) for (int i = 0; i < MW; i++) ref_mem[g][i] = mem_init(i);
      if (!rst_n) begin
        m_last[g] = 1; m_starve[g] = 0; s1_vld[g] = 0; s2_vld[g] = 0;
        m_rdata[g][0] = '0; m_rdata[g][1] = '0;
        chk("rst_ctl", g, 32'({gnt[g][0], gnt[g][1], rvalid[g][0], rvalid[g][1], dm_w[g], dm_r[g]}), 32'h0);
        chk("rst_bus", g, dm_addr[g] | dm_wdata[g] | 32'(dm_op[g]), 32'h0);
        chk("rst_rdata", g, rdata[g][0] | rdata[g][1], 32'h0);
        continue;
      end
      if (s2_vld[g]) m_rdata[g][s2_port[g]] = s2_data[g];
      w = pick(g, req[g][0], req[g][1]);
      chk("gnt0", g, 32'(gnt[g][0]), 32'(w == 0));
      chk("gnt1", g, 32'(gnt[g][1]), 32'(w == 1));
      chk("dm_w", g, 32'(dm_w[g]), 32'(s1_vld[g] && s1_we[g]));
      chk("dm_r", g, 32'(dm_r[g]), 32'(s1_vld[g] && !s1_we[g]));
      if (s1_vld[g]) begin
        chk("dm_addr", g, dm_addr[g], s1_addr[g]);
        chk("dm_wdata", g, dm_wdata[g], s1_wdata[g]);
        chk("dm_op", g, 32'(dm_op[g]), 32'(s1_op[g]));
      end
      chk("rvalid0", g, 32'(rvalid[g][0]), 32'(s2_vld[g] && !s2_port[g]));
      chk("rvalid1", g, 32'(rvalid[g][1]), 32'(s2_vld[g] && s2_port[g]));
      chk("rdata0", g, rdata[g][0], m_rdata[g][0]);
      chk("rdata1", g, rdata[g][1], m_rdata[g][1]);
      s2_vld[g]  = s1_vld[g] && !s1_we[g];
      s2_port[g] = s1_port[g];
      if (s1_vld[g] && !s1_we[g]) s2_data[g] = dm_rd(ref_mem[g][s1_addr[g][7:2]], s1_addr[g], s1_op[g]);
      if (s1_vld[g] && s1_we[g])
        ref_mem[g][s1_addr[g][7:2]] = dm_wr(ref_mem[g][s1_addr[g][7:2]], s1_addr[g], s1_wdata[g], s1_op[g]);
      s1_vld[g] = (w >= 0);
      if (w >= 0) begin
        s1_port[g]  = (w == 1);
        s1_we[g]    = we[g][w];
        s1_addr[g]  = addr[g][w];
        s1_wdata[g] = wdata[g][w];
        s1_op[g]    = op[g][w];
        if (w == 1) m_starve[g] = 0;
        else if (req[g][1] && m_starve[g] < smax[g] - 1) m_starve[g]++;
        m_last[g] = w;
      end
    end
  endtask

  task automatic eval();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    eval();
    adv();
  endtask

  task automatic drive(input int p, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] o);
    for (int g = 0; g < NI; g++) begin
      req[g][p] = r; we[g][p] = w; addr[g][p] = a; wdata[g][p] = d; op[g][p] = o;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, '0, '0, DM_OP_WD);
    drive(1, 0, 0, '0, '0, DM_OP_WD);
    mem_clear = 1'b1;
    cyc();
    mem_clear = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic rand_drive();
    for (int g = 0; g < NI; g++) begin
      for (int p = 0; p < 2; p++) begin
        if (req[g][p] && !last_gnt[g][p]) begin
          if ($urandom_range(0, 7) == 0) req[g][p] = 1'b0;
        end else if ($urandom_range(0, 99) < 60) begin
          req[g][p]   = 1'b1;
          we[g][p]    = 1'($urandom_range(0, 1));
          addr[g][p]  = 32'($urandom_range(0, 255));
          wdata[g][p] = $urandom;
          case ($urandom_range(0, 4))
            0:       op[g][p] = we[g][p] ? DM_OP_SB : DM_OP_BS;
            1:       op[g][p] = we[g][p] ? DM_OP_SH : DM_OP_BZ;
            2:       op[g][p] = we[g][p] ? DM_OP_WD : DM_OP_HS;
            3:       op[g][p] = we[g][p] ? DM_OP_SB : DM_OP_HZ;
            default: op[g][p] = DM_OP_WD;
          endcase
        end else begin
          req[g][p] = 1'b0;
        end
      end
    end
  endtask

  typedef struct {
    bit       r0;
    bit       r1;
    bit [1:0] g_rr;
    bit [1:0] g_fp;
    bit       act;
  } vec_t;

  initial begin
    vec_t tbl[13];
    int   n_g0;
    int   n_acc;
    checks = 0; failures = 0;
    rr   = '{1, 0};
    smax = '{8, 3};
    rst_n = 1'b0;
    mem_clear = 1'b0;
    drive(0, 0, 0, '0, '0, DM_OP_WD);
    drive(1, 0, 0, '0, '0, DM_OP_WD);
    adv();
    do_reset();

    // m0 word read of mem[4]
    drive(0, 1, 0, 32'h10, 32'h0, DM_OP_WD);
    eval();
    for (int g = 0; g < NI; g++) chk("t1_gnt0", g, 32'(gnt[g][0]), 32'h1);
    adv();
    drive(0, 0, 0, 32'h10, 32'h0, DM_OP_WD);
    eval();
    for (int g = 0; g < NI; g++) begin
      chk("t1_dm_r", g, 32'(dm_r[g]), 32'h1);
      chk("t1_addr", g, dm_addr[g], 32'h10);
    end
    adv();
    eval();
    for (int g = 0; g < NI; g++) begin
      chk("t1_rvalid0", g, 32'(rvalid[g][0]), 32'h1);
      chk("t1_rdata0", g, rdata[g][0], 32'hA1B2C3D4);
      chk("t1_m1_idle", g, 32'({gnt[g][1], rvalid[g][1]}), 32'h0);
    end
    adv();

    // m1 byte store then zero-extended byte load of the same address
    drive(1, 1, 1, 32'h20, 32'h000000EE, DM_OP_SB);
    eval();
    for (int g = 0; g < NI; g++) chk("t2_gnt1_wr", g, 32'(gnt[g][1]), 32'h1);
    adv();
    drive(1, 1, 0, 32'h20, 32'h0, DM_OP_BZ);
    eval();
    for (int g = 0; g < NI; g++) begin
      chk("t2_gnt1_rd", g, 32'(gnt[g][1]), 32'h1);
      chk("t2_dm_w", g, 32'(dm_w[g]), 32'h1);
    end
    adv();
    drive(1, 0, 0, 32'h20, 32'h0, DM_OP_BZ);
    eval();
    for (int g = 0; g < NI; g++) chk("t2_dm_r", g, 32'(dm_r[g]), 32'h1);
    adv();
    eval();
    for (int g = 0; g < NI; g++) begin
      chk("t2_rvalid1", g, 32'(rvalid[g][1]), 32'h1);
      chk("t2_rdata1", g, rdata[g][1], 32'h000000EE);
    end
    adv();

    // Grant sequences: {m1,m0} one-hot per row, rr = instance 0, fp = instance 1 (STARVE_MAX=3)
    tbl[0]  = '{1, 1, 2'b01, 2'b01, 0};
    tbl[1]  = '{1, 1, 2'b10, 2'b01, 1};
    tbl[2]  = '{1, 1, 2'b01, 2'b10, 1};
    tbl[3]  = '{1, 1, 2'b10, 2'b01, 1};
    tbl[4]  = '{1, 1, 2'b01, 2'b01, 1};
    tbl[5]  = '{1, 1, 2'b10, 2'b10, 1};
    tbl[6]  = '{0, 1, 2'b10, 2'b10, 1};
    tbl[7]  = '{1, 1, 2'b01, 2'b01, 1};
    tbl[8]  = '{1, 0, 2'b01, 2'b01, 1};
    tbl[9]  = '{1, 1, 2'b10, 2'b01, 1};
    tbl[10] = '{1, 1, 2'b01, 2'b10, 1};
    tbl[11] = '{0, 0, 2'b00, 2'b00, 1};
    tbl[12] = '{0, 0, 2'b00, 2'b00, 0};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(0, tbl[i].r0, 0, 32'h0, 32'h0, DM_OP_WD);
      drive(1, tbl[i].r1, 0, 32'h4, 32'h0, DM_OP_WD);
      eval();
      chk($sformatf("tbl%0d_rr_gnt", i), 0, 32'({gnt[0][1], gnt[0][0]}), 32'(tbl[i].g_rr));
      chk($sformatf("tbl%0d_fp_gnt", i), 1, 32'({gnt[1][1], gnt[1][0]}), 32'(tbl[i].g_fp));
      for (int g = 0; g < NI; g++)
        chk($sformatf("tbl%0d_act", i), g, 32'(dm_w[g] | dm_r[g]), 32'(tbl[i].act));
      adv();
    end

    // Reset asserted during the dm cycle of a write
    do_reset();
    drive(0, 1, 1, 32'h30, 32'h12345678, DM_OP_WD);
    eval();
    for (int g = 0; g < NI; g++) chk("t5_gnt0", g, 32'(gnt[g][0]), 32'h1);
    adv();
    drive(0, 0, 1, 32'h30, 32'h12345678, DM_OP_WD);
    rst_n = 1'b0;
    eval();
    for (int g = 0; g < NI; g++) chk("t5_dm_w_low", g, 32'(dm_w[g]), 32'h0);
    adv();
    rst_n = 1'b1;
    eval();
    chk("t5_mem12", 0, g_inst[0].mem[12], mem_init(12));
    chk("t5_mem12", 1, g_inst[1].mem[12], mem_init(12));
    for (int g = 0; g < NI; g++) chk("t5_idle", g, 32'({dm_w[g], dm_r[g], rvalid[g][0]}), 32'h0);
    adv();
    eval();
    for (int g = 0; g < NI; g++) chk("t5_no_rvalid", g, 32'(rvalid[g][0]), 32'h0);
    adv();

    // m0 loses to m1 under round-robin, then withdraws its request
    do_reset();
    drive(0, 1, 0, 32'h40, 32'h0, DM_OP_WD);
    eval();
    chk("t6_first_gnt0", 0, 32'(gnt[0][0]), 32'h1);
    adv();
    drive(0, 1, 0, 32'h48, 32'h0, DM_OP_WD);
    drive(1, 1, 0, 32'h44, 32'h0, DM_OP_WD);
    eval();
    chk("t6_lose_gnt0", 0, 32'(gnt[0][0]), 32'h0);
    chk("t6_win_gnt1", 0, 32'(gnt[0][1]), 32'h1);
    adv();
    drive(0, 0, 0, 32'h48, 32'h0, DM_OP_WD);
    drive(1, 0, 0, 32'h44, 32'h0, DM_OP_WD);
    n_g0 = 0;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      eval();
      n_g0  += int'(gnt[0][0]);
      n_acc += int'(dm_r[0] | dm_w[0]);
      adv();
    end
    chk("t6_no_m0_gnt", 0, 32'(n_g0), 32'h0);
    chk("t6_one_access", 0, 32'(n_acc), 32'h1);

    // Random traffic with one reset pulse in the middle
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_drive();
      if (i == 300) rst_n = 1'b0;
      if (i == 302) rst_n = 1'b1;
      cyc();
    end
    drive(0, 0, 0, '0, '0, DM_OP_WD);
    drive(1, 0, 0, '0, '0, DM_OP_WD);
    for (int i = 0; i < 4; i++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
